// File: rtl/iir_out_buffer.sv
// Elastic output buffer for iir_filter: strobe-in, valid/ready-out FIFO with sticky overflow.
// Optional peak-magnitude tracker on accepted samples, enabled by defining IIR_OUT_PEAK_EN.
module iir_out_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             VOUT,
  input  logic             READY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic             OVF,
`ifdef IIR_OUT_PEAK_EN
  output logic [WIDTH-1:0] PEAK,
`endif
  input  logic             CLR_OVF
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            vout_q;
  logic            ovf_q;
  logic            pop, push, drop, full;

  assign full = (state_q == StFull);
  assign pop  = vout_q & READY;
  // A full buffer still accepts a sample when the consumer frees a slot in the same cycle.
  assign push = VIN & (~full | pop);
  assign drop = VIN & full & ~pop;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = StPartial;
    if (level_d == '0) begin
      state_d = StEmpty;
    end else if (level_d == LevelFull) begin
      state_d = StFull;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StEmpty;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      vout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      vout_q  <= (state_d != StEmpty);
      // Drop has priority over a simultaneous clear.
      ovf_q   <= drop | (ovf_q & ~CLR_OVF);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage carries no reset; stale entries are masked by VOUT.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_ptr_q] <= DIN;
    end
  end

  assign DOUT  = vout_q ? mem[rd_ptr_q] : '0;
  assign VOUT  = vout_q;
  assign LEVEL = level_q;
  assign OVF   = ovf_q;

`ifdef IIR_OUT_PEAK_EN
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MaxPos = ~MinNeg;

  logic [WIDTH-1:0] abs_din;
  logic [WIDTH-1:0] peak_q;

  // Saturating magnitude so the most negative code still fits as a positive value.
  always_comb begin
    abs_din = DIN;
    if (DIN[WIDTH-1]) begin
      abs_din = (DIN == MinNeg) ? MaxPos : (~DIN + WIDTH'(1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      peak_q <= '0;
    end else if (push && (abs_din > peak_q)) begin
      peak_q <= abs_din;
    end
  end

  assign PEAK = peak_q;
`endif

endmodule

// File: tb/tb_iir_out_buffer.sv
// Self-checking bench for iir_out_buffer: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_iir_out_buffer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIN;
  logic       VIN;
  logic [7:0] DOUT;
  logic       VOUT;
  logic       READY;
  logic [3:0] LEVEL;
  logic       OVF;
  logic       CLR_OVF;
`ifdef IIR_OUT_PEAK_EN
  logic [7:0] PEAK;
`endif

  iir_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .VIN     (VIN),
    .DOUT    (DOUT),
    .VOUT    (VOUT),
    .READY   (READY),
    .LEVEL   (LEVEL),
    .OVF     (OVF),
`ifdef IIR_OUT_PEAK_EN
    .PEAK    (PEAK),
`endif
    .CLR_OVF (CLR_OVF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       m_ovf;
  logic [7:0] m_peak;

  // One clock of stimulus; the model applies the buffer's rules to the same inputs.
  task automatic drive(input logic vin, input logic [7:0] din, input logic ready,
                       input logic clr);
    bit pop, push, drop;
    int mag;
    VIN = vin; DIN = din; READY = ready; CLR_OVF = clr;
    pop  = (mq.size() != 0) && ready;
    push = vin && ((mq.size() < DEPTH) || pop);
    drop = vin && !push;
    @(posedge CLK);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(din);
      mag = $signed(din);
      if (mag < 0) mag = -mag;
      if (mag > 127) mag = 127;
      if (mag > int'(m_peak)) m_peak = 8'(mag);
    end
    m_ovf = drop || (m_ovf && !clr);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; VIN = 1'b1; DIN = 8'hAA; READY = 1'b0; CLR_OVF = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0; VIN = 1'b0;
    mq.delete();
    m_ovf  = 1'b0;
    m_peak = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (VOUT !== 1'b0) begin errors++; $display("FAIL reset_vout: got %b expected 0", VOUT); end
    checks++;
    if (LEVEL !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", LEVEL); end
    checks++;
    if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", OVF); end
    checks++;
    if (DOUT !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", DOUT); end
  endtask

  task automatic test_fall_through();
    do_reset();
    drive(1'b1, 8'h35, 1'b0, 1'b0);
    checks++;
    if (VOUT !== 1'b1 || DOUT !== 8'h35 || LEVEL !== 4'd1) begin
      errors++;
      $display("FAIL fall_through: got vout=%b dout=%h level=%0d expected 1 35 1", VOUT, DOUT, LEVEL);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (DOUT !== 8'h35 || VOUT !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable: got dout=%h vout=%b expected 35 1", DOUT, VOUT);
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (VOUT !== 1'b0 || LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL single_pop: got vout=%b level=%0d expected 0 0", VOUT, LEVEL);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 4'd8 || OVF !== 1'b0) begin
      errors++;
      $display("FAIL fill_level: got level=%0d ovf=%b expected 8 0", LEVEL, OVF);
    end
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 4'd8 || OVF !== 1'b1) begin
      errors++;
      $display("FAIL drop: got level=%0d ovf=%b expected 8 1", LEVEL, OVF);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (VOUT !== 1'b1 || DOUT !== 8'(i)) begin
        errors++;
        $display("FAIL drain_order: got vout=%b dout=%h expected 1 %h", VOUT, DOUT, 8'(i));
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (VOUT !== 1'b0 || LEVEL !== 4'd0 || OVF !== 1'b1) begin
      errors++;
      $display("FAIL drained: got vout=%b level=%0d ovf=%b expected 0 0 1", VOUT, LEVEL, OVF);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] last;
    do_reset();
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h0A, 1'b1, 1'b0);
    checks++;
    if (LEVEL !== 4'd8 || OVF !== 1'b0 || DOUT !== 8'h02) begin
      errors++;
      $display("FAIL full_push_pop: got level=%0d ovf=%b dout=%h expected 8 0 02", LEVEL, OVF, DOUT);
    end
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last = DOUT;
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++;
    if (last !== 8'h0A || VOUT !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_last: got last=%h vout=%b expected 0a 0", last, VOUT);
    end
  endtask

  task automatic test_clr_ovf();
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (OVF !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", OVF); end
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    checks++;
    if (OVF !== 1'b1 || LEVEL !== 4'd8) begin
      errors++;
      $display("FAIL drop_beats_clr: got ovf=%b level=%0d expected 1 8", OVF, LEVEL);
    end
    checks++;
    if (DOUT !== 8'h40) begin errors++; $display("FAIL drop_untouched: got %h expected 40", DOUT); end
  endtask

  task automatic test_stream();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      drive(1'b1, d, 1'b1, 1'b0);
      checks++;
      if (VOUT !== 1'b1 || DOUT !== d || LEVEL !== 4'd1) begin
        errors++;
        $display("FAIL stream[%0d]: got vout=%b dout=%h level=%0d expected 1 %h 1",
                 i, VOUT, DOUT, LEVEL, d);
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (VOUT !== 1'b0 || LEVEL !== 4'd0) begin
      errors++;
      $display("FAIL stream_end: got vout=%b level=%0d expected 0 0", VOUT, LEVEL);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      // Phases alternate between fill-biased and drain-biased traffic.
      drive(($urandom_range(99) < 70) ? 1'b1 : 1'b0, 8'($urandom),
            ($urandom_range(99) < (((i / 50) % 2 == 0) ? 25 : 85)) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 4) ? 1'b1 : 1'b0);
      checks++;
      if (VOUT !== (mq.size() != 0) || LEVEL !== 4'(mq.size()) || OVF !== m_ovf ||
          (mq.size() != 0 && DOUT !== mq[0])) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: got vout=%b level=%0d ovf=%b dout=%h expected level=%0d ovf=%b",
                   i, VOUT, LEVEL, OVF, DOUT, mq.size(), m_ovf);
      end
`ifdef IIR_OUT_PEAK_EN
      checks++;
      if (PEAK !== m_peak) begin
        errors++;
        $display("FAIL random_peak[%0d]: got %h expected %h", i, PEAK, m_peak);
      end
`endif
    end
  endtask

`ifdef IIR_OUT_PEAK_EN
  task automatic test_peak();
    logic [7:0] vals [3];
    logic [7:0] exp  [3];
    vals = '{8'h10, 8'hF0, 8'h80};
    exp  = '{8'h10, 8'h10, 8'h7F};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1, 1'b0);
      checks++;
      if (PEAK !== exp[i]) begin
        errors++;
        $display("FAIL peak[%0d]: got %h expected %h", i, PEAK, exp[i]);
      end
    end
    do_reset();
    checks++;
    if (PEAK !== 8'h00) begin errors++; $display("FAIL peak_reset: got %h expected 00", PEAK); end
  endtask
`endif

  initial begin
    test_reset();
    test_fall_through();
    test_overflow();
    test_full_push_pop();
    test_clr_ovf();
    test_stream();
    test_random();
`ifdef IIR_OUT_PEAK_EN
    test_peak();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_out_buffer.md
# iir_out_buffer

Output elastic buffer placed directly downstream of `iir_filter`. It captures every filtered sample presented on the filter's `DOUT`/`VOUT` strobe interface, which has no backpressure, into a small FIFO. It then re-presents the samples to the consumer (`data_sink` or a later stage) over a valid/ready handshake. Samples that arrive while the buffer is full are dropped and flagged with a sticky overflow bit.

## Interface
- `WIDTH`, 8, sample width in bits; two's complement, matches the filter output.
- `DEPTH`, 8, FIFO depth in samples; must be a power of two, ≥ 2.
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST` in 1: synchronous, active-high reset.
- `DIN` in WIDTH: sample from `iir_filter` `DOUT`.
- `VIN` in 1: sample strobe from `iir_filter` `VOUT`; one sample per asserted cycle.
- `DOUT` out WIDTH: head-of-FIFO sample.
- `VOUT` out 1: `DOUT` valid (FIFO not empty).
- `READY` in 1: consumer accepts `DOUT` this cycle.
- `LEVEL` out log2(DEPTH)+1: number of stored samples, 0..DEPTH.
- `OVF` out 1: sticky overflow flag.
- `CLR_OVF` in 1: clears `OVF`.
- `PEAK` out WIDTH: peak magnitude of accepted samples. Present only with `IIR_OUT_PEAK_EN`.

## Operation
- Storage: DEPTH×WIDTH register array, with write pointer and read pointer of log2(DEPTH) bits each. Both pointers wrap modulo DEPTH.
- `LEVEL` is a registered counter, not derived from the pointers.
- Pop: occurs when `VOUT && READY`. The read pointer advances.
- Push: occurs when `VIN` is high and at least one of these holds:
  - `LEVEL < DEPTH`, or
  - a pop occurs in the same cycle.

  On a push, `DIN` is written at the write pointer and the write pointer advances.
- Simultaneous push and pop: `LEVEL` is unchanged. This holds even when the buffer is full (no overflow) or empty (cannot pop when empty, so empty+push simply stores the sample).
- Drop: occurs when `VIN` is high, `LEVEL == DEPTH`, and there is no pop. The sample is discarded, pointers and `LEVEL` are unchanged, and `OVF` is set at the next edge.
- `OVF` stays high until `CLR_OVF` or `RST`. If a drop and `CLR_OVF` occur in the same cycle, set wins and `OVF` stays 1.
- `READY` while `VOUT` = 0 has no effect.
- Handshake rule: `DOUT` holds stable while `VOUT && !READY`.
- Control is a three-state FSM: EMPTY (`LEVEL` = 0), PARTIAL, FULL (`LEVEL` = DEPTH). The state is encoded by `LEVEL`, and `VOUT = (LEVEL != 0)`.
- Reset mid-operation: all contents are discarded and the pointers return to 0. `VIN` during the `RST` cycle is ignored.

## Timing
- Reset values: `VOUT` = 0, `LEVEL` = 0, `OVF` = 0, `DOUT` = 0, `PEAK` = 0. Memory contents are don't-care but are never exposed while `VOUT` = 0.
- Fall-through latency: a push into an empty buffer at edge t gives `VOUT` = 1 and `DOUT` = that sample in the cycle after edge t (1 cycle).
- `DOUT` is read from the registered array at the registered read pointer. There is no combinational path from `DIN` to `DOUT`.
- `LEVEL` and `OVF` update at the same edge as the push, pop, or drop that causes them.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- `READY` may be driven combinationally by the consumer. `VOUT` does not depend combinationally on `READY`.

## Configuration
- `IIR_OUT_PEAK_EN` defined:
  - The `PEAK` port and register exist.
  - On every accepted push, `PEAK` is updated to max(`PEAK`, |DIN|) at that edge.
  - |DIN| saturates: the most negative value (−2^(WIDTH−1), i.e. −128 for `WIDTH` = 8) maps to 2^(WIDTH−1)−1 (127).
  - Dropped samples do not update `PEAK`. Only `RST` clears `PEAK`.
- `IIR_OUT_PEAK_EN` undefined: no `PEAK` port, no register; all other behaviour is identical.

## Test plan
- Reset, then push one sample 0x35 with `READY` = 0 → in the next cycle `VOUT` = 1, `DOUT` = 0x35, `LEVEL` = 1. Hold `READY` = 0 for 5 cycles → `DOUT` stays 0x35. Pulse `READY` → `VOUT` = 0, `LEVEL` = 0.
- `READY` = 0, push 8 samples 0x01..0x08 → `LEVEL` = 8. Push 0x09 → `OVF` = 1, `LEVEL` = 8. Drain → exactly 0x01..0x08 appear in order.
- Buffer full, `VIN` with 0x0A and `READY` = 1 in the same cycle → `OVF` stays 0, `LEVEL` = 8, 0x0A is the last sample drained.
- `OVF` = 1, assert `CLR_OVF` alone → `OVF` = 0. With the buffer full, drop and `CLR_OVF` in the same cycle → `OVF` = 1.
- Continuous `VIN` of 20 samples with `READY` = 1 throughout → output matches the input sequence, 1-cycle delay, `LEVEL` ≤ 1, pointers wrap correctly.
- With `IIR_OUT_PEAK_EN`: push 0x10, 0xF0 (−16), 0x80 (−128) → `PEAK` = 0x10, 0x10, 0x7F. `RST` → `PEAK` = 0.
